// File: rtl/uart_rx_frame.sv
// UART receiver with configurable data width, parity and stop bits.
// Reports parity, framing and break errors with each received word.
module uart_rx_frame #(
    parameter int CLK_PER_BIT   = 104,
    parameter int COUNTER_WIDTH = 7,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 rx_busy
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StPar      = 3'd3;
    localparam logic [2:0] StStop     = 3'd4;
    localparam logic [2:0] StWaitHigh = 3'd5;

    localparam logic [COUNTER_WIDTH-1:0] HalfM1 = COUNTER_WIDTH'(CLK_PER_BIT / 2 - 1);
    localparam logic [COUNTER_WIDTH-1:0] FullM1 = COUNTER_WIDTH'(CLK_PER_BIT - 1);
    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);
    localparam logic       OddPar   = (PARITY == 1);

    logic                     s1;
    logic                     rx_s;
    logic [2:0]               state;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [DATA_BITS-1:0]     shreg;
    logic [3:0]               idx;
    logic                     par_bad;
    logic                     stop_bad;
    // Parity and stop samples seen so far were all low (break candidate)
    logic                     ctl_low;

    logic tick_half;
    logic tick_full;
    logic fe_next;
    logic bd_next;

    always_comb begin
        tick_half = (cnt == HalfM1);
        tick_full = (cnt == FullM1);
        fe_next   = stop_bad | ~rx_s;
        bd_next   = (shreg == '0) & ctl_low & ~rx_s;
    end

    assign rx_busy = (state != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1         <= 1'b1;
            rx_s       <= 1'b1;
            state      <= StIdle;
            cnt        <= '0;
            shreg      <= '0;
            idx        <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            ctl_low    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            s1       <= uart_rx;
            rx_s     <= s1;
            rx_valid <= 1'b0;
            case (state)
                StIdle: begin
                    cnt <= '0;
                    if (!rx_s) state <= StStart;
                end
                StStart: begin
                    if (tick_half) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= StIdle;
                        end else begin
                            state    <= StData;
                            idx      <= '0;
                            par_bad  <= 1'b0;
                            stop_bad <= 1'b0;
                            ctl_low  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (tick_full) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == LastData) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? StPar : StStop;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StPar: begin
                    if (tick_full) begin
                        cnt     <= '0;
                        par_bad <= ((^shreg) ^ rx_s) != OddPar;
                        ctl_low <= ctl_low & ~rx_s;
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_full) begin
                        cnt <= '0;
                        if (idx == LastStop) begin
                            idx        <= '0;
                            rx_data    <= shreg;
                            rx_valid   <= 1'b1;
                            parity_err <= (PARITY != 0) & par_bad;
                            frame_err  <= fe_next;
                            break_det  <= bd_next;
                            state      <= fe_next ? StWaitHigh : StIdle;
                        end else begin
                            idx      <= idx + 1'b1;
                            stop_bad <= fe_next;
                            ctl_low  <= ctl_low & ~rx_s;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    cnt <= '0;
                    if (rx_s) state <= StIdle;
                end
                default: begin
                    cnt   <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: three instances (8N1, 8E1, 7E2) driven
// with directed frames; monitors pop expected words whenever rx_valid pulses.
module tb_uart_rx_frame;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] line = 3'b111;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         valid_cyc0 = 0;
    int         c0;
    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       q2[$];
    exp_t       w0, w1, w2;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic v0, pe0, fe0, bd0, b0;
    logic v1, pe1, fe1, bd1, b1;
    logic v2, pe2, fe2, bd2, b2;

    uart_rx_frame #(
        .CLK_PER_BIT(104), .COUNTER_WIDTH(7), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_8n1 (
        .clk(clk), .reset(rst[0]), .uart_rx(line[0]), .rx_data(d0), .rx_valid(v0),
        .parity_err(pe0), .frame_err(fe0), .break_det(bd0), .rx_busy(b0)
    );

    uart_rx_frame #(
        .CLK_PER_BIT(16), .COUNTER_WIDTH(5), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u_8e1 (
        .clk(clk), .reset(rst[1]), .uart_rx(line[1]), .rx_data(d1), .rx_valid(v1),
        .parity_err(pe1), .frame_err(fe1), .break_det(bd1), .rx_busy(b1)
    );

    uart_rx_frame #(
        .CLK_PER_BIT(16), .COUNTER_WIDTH(5), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) u_7e2 (
        .clk(clk), .reset(rst[2]), .uart_rx(line[2]), .rx_data(d2), .rx_valid(v2),
        .parity_err(pe2), .frame_err(fe2), .break_det(bd2), .rx_busy(b2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic chk_frame(input string tag, input exp_t got, input exp_t want);
        chk({tag, "_data"}, int'(got.data), int'(want.data));
        chk({tag, "_parity_err"}, int'(got.pe), int'(want.pe));
        chk({tag, "_frame_err"}, int'(got.fe), int'(want.fe));
        chk({tag, "_break_det"}, int'(got.bd), int'(want.bd));
    endtask

    task automatic unexpected(input string tag, input int data);
        total++;
        bad++;
        $display("FAIL %s: unexpected rx_valid, data %0h, expected no frame", tag, data);
    endtask

    function automatic exp_t mk(input logic [8:0] data, input logic pe, input logic fe,
                                input logic bd);
        exp_t e;
        e.data = data;
        e.pe   = pe;
        e.fe   = fe;
        e.bd   = bd;
        return e;
    endfunction

    // Monitors
    always @(negedge clk) begin
        if (v0) begin
            valid_cyc0 = cyc;
            if (q0.size() == 0) unexpected("u8n1", int'(d0));
            else begin
                w0 = q0.pop_front();
                chk_frame("u8n1", mk({1'b0, d0}, pe0, fe0, bd0), w0);
            end
        end
    end

    always @(negedge clk) begin
        if (v1) begin
            if (q1.size() == 0) unexpected("u8e1", int'(d1));
            else begin
                w1 = q1.pop_front();
                chk_frame("u8e1", mk({1'b0, d1}, pe1, fe1, bd1), w1);
            end
        end
    end

    always @(negedge clk) begin
        if (v2) begin
            if (q2.size() == 0) unexpected("u7e2", int'(d2));
            else begin
                w2 = q2.pop_front();
                chk_frame("u7e2", mk({2'b0, d2}, pe2, fe2, bd2), w2);
            end
        end
    end

    task automatic drive(input int idx, input logic b, input int n);
        line[idx] = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input int cpb, input int nd, input logic [8:0] data,
                        input int npar, input logic pbit, input int nstop, input logic stopv);
        drive(idx, 1'b0, cpb);
        for (int i = 0; i < nd; i++) drive(idx, data[i], cpb);
        if (npar != 0) drive(idx, pbit, cpb);
        for (int i = 0; i < nstop; i++) drive(idx, stopv, cpb);
        line[idx] = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] v33;
        v33 = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_data", int'(d0), 0);
        chk("reset_rx_valid", int'(v0), 0);
        chk("reset_rx_busy", int'(b0), 0);
        chk("reset_flags", int'({pe0, fe0, bd0}), 0);
        rst = 3'b000;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 nominal with latency check
        c0 = cyc;
        q0.push_back(mk(9'h33, 1'b0, 1'b0, 1'b0));
        send(0, 104, 8, 9'h33, 0, 1'b0, 1, 1'b1);
        chk("first_valid_cycle", valid_cyc0 - c0, 991);
        q0.push_back(mk(9'h35, 1'b0, 1'b0, 1'b0));
        send(0, 104, 8, 9'h35, 0, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        // Framing error, data nonzero
        q0.push_back(mk(9'h30, 1'b0, 1'b1, 1'b0));
        send(0, 104, 8, 9'h30, 0, 1'b0, 1, 1'b0);
        repeat (300) @(posedge clk);
        #1;
        chk("frame_err_back_idle_busy", int'(b0), 0);

        // Break: line low for three frame times
        q0.push_back(mk(9'h00, 1'b0, 1'b1, 1'b1));
        drive(0, 1'b0, 3 * 10 * 104);
        chk("break_wait_high_busy", int'(b0), 1);
        drive(0, 1'b1, 10);
        chk("break_released_busy", int'(b0), 0);
        q0.push_back(mk(9'h31, 1'b0, 1'b0, 1'b0));
        send(0, 104, 8, 9'h31, 0, 1'b0, 1, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        // Glitch rejection
        drive(0, 1'b0, 10);
        chk("glitch_busy_during", int'(b0), 1);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 40);
        chk("glitch_busy_after", int'(b0), 0);
        chk("glitch_data_held", int'(d0), 'h31);
        chk("glitch_flags_held", int'({pe0, fe0, bd0}), 0);

        // Reset during data bit 4
        drive(0, 1'b0, 104);
        for (int i = 0; i < 4; i++) drive(0, v33[i], 104);
        drive(0, v33[4], 52);
        rst[0] = 1'b1;
        #1;
        chk("midreset_rx_data", int'(d0), 0);
        chk("midreset_rx_valid", int'(v0), 0);
        chk("midreset_rx_busy", int'(b0), 0);
        line[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        q0.push_back(mk(9'h33, 1'b0, 1'b0, 1'b0));
        send(0, 104, 8, 9'h33, 0, 1'b0, 1, 1'b1);

        // Even parity: 0x35 has four ones, parity bit 1 is wrong, 0 is right
        q1.push_back(mk(9'h35, 1'b1, 1'b0, 1'b0));
        send(1, 16, 8, 9'h35, 1, 1'b1, 1, 1'b1);
        q1.push_back(mk(9'h35, 1'b0, 1'b0, 1'b0));
        send(1, 16, 8, 9'h35, 1, 1'b0, 1, 1'b1);

        // 7E2 back-to-back
        q2.push_back(mk(9'h13, 1'b0, 1'b0, 1'b0));
        q2.push_back(mk(9'h7F, 1'b0, 1'b0, 1'b0));
        q2.push_back(mk(9'h00, 1'b0, 1'b0, 1'b0));
        send(2, 16, 7, 9'h13, 1, 1'b1, 2, 1'b1);
        send(2, 16, 7, 9'h7F, 1, 1'b1, 2, 1'b1);
        send(2, 16, 7, 9'h00, 1, 1'b0, 2, 1'b1);

        repeat (50) @(posedge clk);
        #1;
        chk("u8n1_frames_pending", q0.size(), 0);
        chk("u8e1_frames_pending", q1.size(), 0);
        chk("u7e2_frames_pending", q2.size(), 0);
        chk("u7e2_idle_at_end", int'(b2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
